// File: rtl/dclk_ctrl.sv
// Timebase and set-mode control for the digital clock: divides clk into a seconds
// enable, chains counter wraps into minute/hour enables, and handles push-button time set.
module dclk_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic timeset,
  input  logic minadv,
  input  logic hradv,
  input  logic sec_wrap,
  input  logic min_wrap,
  output logic sec_en,
  output logic min_en,
  output logic hr_en,
  output logic sec_clr,
  output logic set_mode
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]    ts_sync_r;
  logic [2:0]    min_sync_r, hr_sync_r;   // [1:0] synchronizer, [2] previous value
  logic          min_pulse_s, hr_pulse_s, tick_s;
  logic          sec_en_r, min_en_r, hr_en_r, sec_clr_r, set_mode_r;
  logic          sec_en_nxt_s, min_en_nxt_s, hr_en_nxt_s, sec_clr_nxt_s, set_mode_nxt_s;

  assign min_pulse_s = min_sync_r[1] & ~min_sync_r[2];
  assign hr_pulse_s  = hr_sync_r[1] & ~hr_sync_r[2];
  assign tick_s      = (state_r == RUN) && (cnt_r == CNT_MAX);

  // Two-flop synchronizers plus edge-detect history for the buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_sync_r  <= 2'b00;
      min_sync_r <= 3'b000;
      hr_sync_r  <= 3'b000;
    end else begin
      ts_sync_r  <= {ts_sync_r[0], timeset};
      min_sync_r <= {min_sync_r[1:0], minadv};
      hr_sync_r  <= {hr_sync_r[1:0], hradv};
    end
  end

  // Next state, prescaler and output values, all derived from the pre-edge state.
  always_comb begin
    state_nxt_s   = RUN;
    cnt_nxt_s     = {CW{1'b0}};
    sec_en_nxt_s  = 1'b0;
    min_en_nxt_s  = 1'b0;
    hr_en_nxt_s   = 1'b0;
    sec_clr_nxt_s = 1'b0;
    case (state_r)
      RUN: begin
        state_nxt_s = ts_sync_r[1] ? SET : RUN;
        if (cnt_r >= CNT_MAX) begin
          cnt_nxt_s = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
        sec_en_nxt_s = tick_s;
        min_en_nxt_s = sec_wrap;
        hr_en_nxt_s  = min_wrap;
      end
      SET: begin
        // Wraps are dropped here so a minute rollover while setting never carries.
        state_nxt_s   = ts_sync_r[1] ? SET : RUN;
        cnt_nxt_s     = {CW{1'b0}};
        min_en_nxt_s  = min_pulse_s;
        hr_en_nxt_s   = hr_pulse_s;
        sec_clr_nxt_s = ~ts_sync_r[1];
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
    set_mode_nxt_s = (state_nxt_s == SET);
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= RUN;
      cnt_r      <= {CW{1'b0}};
      sec_en_r   <= 1'b0;
      min_en_r   <= 1'b0;
      hr_en_r    <= 1'b0;
      sec_clr_r  <= 1'b0;
      set_mode_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sec_en_r   <= sec_en_nxt_s;
      min_en_r   <= min_en_nxt_s;
      hr_en_r    <= hr_en_nxt_s;
      sec_clr_r  <= sec_clr_nxt_s;
      set_mode_r <= set_mode_nxt_s;
    end
  end

  assign sec_en   = sec_en_r;
  assign min_en   = min_en_r;
  assign hr_en    = hr_en_r;
  assign sec_clr  = sec_clr_r;
  assign set_mode = set_mode_r;

endmodule

// File: tb/tb_dclk_ctrl.sv
// Self-checking bench for dclk_ctrl: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against an input-history reference model.
module tb_dclk_ctrl;

  localparam int TD   = 4;
  localparam int MAXE = 16384;

  logic clk = 1'b0;
  logic rst;
  logic timeset, minadv, hradv, sec_wrap, min_wrap;
  logic sec_en, min_en, hr_en, sec_clr, set_mode;

  int vectors = 0;
  int errs    = 0;

  dclk_ctrl #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .timeset  (timeset),
    .minadv   (minadv),
    .hradv    (hradv),
    .sec_wrap (sec_wrap),
    .min_wrap (min_wrap),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .sec_clr  (sec_clr),
    .set_mode (set_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sec_en"},   sec_en,   1'b0);
    chk({tag, "_min_en"},   min_en,   1'b0);
    chk({tag, "_hr_en"},    hr_en,    1'b0);
    chk({tag, "_sec_clr"},  sec_clr,  1'b0);
    chk({tag, "_set_mode"}, set_mode, 1'b0);
  endtask

  // Reference model: raw inputs recorded per edge since reset release. Synchronized
  // state before edge n reflects timeset sampled at edge n-3, after it edge n-2.
  bit ts_h [-3:MAXE];
  bit mn_h [-3:MAXE];
  bit hr_h [-3:MAXE];
  int n = 0;
  int run_edges = 0;
  logic e_sec_en, e_min_en, e_hr_en, e_sec_clr, e_set_mode;

  always begin
    @(posedge clk);
    if (!rst) begin
      n = 0;
      run_edges = 0;
      for (int i = -3; i <= 0; i++) begin
        ts_h[i] = 1'b0; mn_h[i] = 1'b0; hr_h[i] = 1'b0;
      end
      {e_sec_en, e_min_en, e_hr_en, e_sec_clr, e_set_mode} = 5'b00000;
    end else begin
      if (n < MAXE) n = n + 1;
      ts_h[n] = timeset;
      mn_h[n] = minadv;
      hr_h[n] = hradv;
      e_set_mode = ts_h[n-2];
      e_sec_clr  = ts_h[n-3] & ~ts_h[n-2];
      if (ts_h[n-3]) begin
        e_sec_en  = 1'b0;
        e_min_en  = mn_h[n-2] & ~mn_h[n-3];
        e_hr_en   = hr_h[n-2] & ~hr_h[n-3];
        run_edges = 0;
      end else begin
        e_sec_en  = ((run_edges % TD) == TD - 1) ? 1'b1 : 1'b0;
        e_min_en  = sec_wrap;
        e_hr_en   = min_wrap;
        run_edges = run_edges + 1;
      end
    end
    #1;
    chk("model_sec_en",   sec_en,   e_sec_en);
    chk("model_min_en",   min_en,   e_min_en);
    chk("model_hr_en",    hr_en,    e_hr_en);
    chk("model_sec_clr",  sec_clr,  e_sec_clr);
    chk("model_set_mode", set_mode, e_set_mode);
  end

  initial begin
    int cnt;
    int pos;
    rst = 1'b0;
    {timeset, minadv, hradv, sec_wrap, min_wrap} = 5'b00000;
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Seconds cadence after reset release: high after edges 4, 8, 12, 16, 20.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("cadence_sec_en", sec_en, (i % TD == 0) ? 1'b1 : 1'b0);
    end

    // Wrap forwarding, one edge of latency.
    sec_wrap = 1'b1;
    @(negedge clk);
    sec_wrap = 1'b0;
    chk("wrap_min_en_hi", min_en, 1'b1);
    min_wrap = 1'b1;
    @(negedge clk);
    min_wrap = 1'b0;
    chk("wrap_min_en_lo", min_en, 1'b0);
    chk("wrap_hr_en_hi", hr_en, 1'b1);
    @(negedge clk);
    chk("wrap_hr_en_lo", hr_en, 1'b0);

    // Enter SET; a sec_wrap while the state is still RUN is forwarded.
    timeset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("enter_set_mode_early", set_mode, 1'b0);
    sec_wrap = 1'b1;
    @(negedge clk);
    sec_wrap = 1'b0;
    chk("enter_set_mode", set_mode, 1'b1);
    chk("edge_wrap_min_en", min_en, 1'b1);
    sec_wrap = 1'b1;
    @(negedge clk);
    sec_wrap = 1'b0;
    @(negedge clk);
    chk("set_wrap_dropped", min_en, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("set_sec_en_quiet", sec_en, 1'b0);
    end

    // Held button yields one pulse, three edges after the press.
    cnt = 0; pos = 0;
    minadv = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (min_en) begin cnt++; pos = i; end
      if (i == 10) minadv = 1'b0;
    end
    chk("minadv_one_pulse", (cnt == 1) ? 1'b1 : 1'b0, 1'b1);
    chk("minadv_latency3", (pos == 3) ? 1'b1 : 1'b0, 1'b1);
    cnt = 0; pos = 0;
    hradv = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (hr_en) begin cnt++; pos = i; end
      if (i == 10) hradv = 1'b0;
    end
    chk("hradv_one_pulse", (cnt == 1) ? 1'b1 : 1'b0, 1'b1);
    chk("hradv_latency3", (pos == 3) ? 1'b1 : 1'b0, 1'b1);
    min_wrap = 1'b1;
    @(negedge clk);
    min_wrap = 1'b0;
    chk("set_min_wrap_no_carry", hr_en, 1'b0);

    // Leave SET: one-cycle sec_clr, prescaler restarts from zero.
    timeset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("leave_sec_clr_early", sec_clr, 1'b0);
    @(negedge clk);
    chk("leave_sec_clr", sec_clr, 1'b1);
    chk("leave_set_mode", set_mode, 1'b0);
    for (int k = 1; k <= TD; k++) begin
      @(negedge clk);
      chk("leave_sec_clr_once", sec_clr, 1'b0);
      chk("leave_first_sec_en", sec_en, (k == TD) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset mid-count with buttons held across release.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    minadv = 1'b1;
    hradv  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("rel_sec_en", sec_en, (i % TD == 0) ? 1'b1 : 1'b0);
      chk("rel_min_en_quiet", min_en, 1'b0);
      chk("rel_hr_en_quiet", hr_en, 1'b0);
    end
    minadv = 1'b0;
    hradv  = 1'b0;

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      sec_wrap = ($urandom_range(0, 9) == 0);
      min_wrap = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 39) == 0) timeset = ~timeset;
      if ($urandom_range(0, 5) == 0) minadv = ~minadv;
      if ($urandom_range(0, 5) == 0) hradv = ~hradv;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rand_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
